// File: rtl/if_fetch_pkg.sv
// Shared definitions for the if_fetch instruction-fetch stage: reset/stall/branch
// encodings, bus widths, the bubble instruction and the fetch FSM states.
package if_fetch_pkg;

  localparam logic RST_ENABLE       = 1'b1;
  localparam int   INST_ADDR_W      = 16;
  localparam int   INST_W           = 16;

  localparam logic [INST_W-1:0]      INST_NOP       = 16'h0800;
  localparam logic [INST_ADDR_W-1:0] ZERO_INST_ADDR = 16'h0000;

  localparam logic STALL_YES        = 1'b1;
  localparam logic STALL_NO         = 1'b0;
  localparam logic BRANCH_FLAG_UP   = 1'b1;
  localparam logic BRANCH_FLAG_DOWN = 1'b0;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    FULL  = 2'd1,
    DROP  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_fifo.sv
// Small synchronous FIFO holding fetched {pc, inst} entries; supports a
// simultaneous push/pop and a synchronous clear used on branch redirect.
module if_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only legal when a pop frees the head on the same edge.
  assign do_push = push && ((count < CNT_W'(DEPTH)) || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding imem requests,
// buffers returned words and presents {pc_o, inst_o} to decode. Optional macro
// IF_FETCH_BYPASS_EN lets an ack into an empty FIFO load the output register directly.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int                ADDR_W     = INST_ADDR_W,
  parameter int                DATA_W     = INST_W,
  parameter logic [ADDR_W-1:0] RESET_PC   = ZERO_INST_ADDR,
  parameter logic [DATA_W-1:0] NOP_INST   = INST_NOP,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_addr_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [DATA_W-1:0] imem_data_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [DATA_W-1:0] inst_o,
  output logic              valid_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int ENT_W = ADDR_W + DATA_W;

  fetch_state_e      state;
  fetch_state_e      state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic              req_nxt;

  logic              hold;
  logic              redirect;
  logic              xfer;
  logic              bypass;
  logic              push;
  logic              pop;
  logic              room;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  count_after;
  logic [ENT_W-1:0]  fifo_head;

  assign hold     = (stall_i == STALL_YES);
  assign redirect = (branch_flag_i == BRANCH_FLAG_UP) && !hold;
  assign xfer     = imem_req_o && imem_ack_i;

`ifdef IF_FETCH_BYPASS_EN
  assign bypass = xfer && (state != DROP) && !redirect && !hold && fifo_empty;
`else
  assign bypass = 1'b0;
`endif

  // Data acked in DROP or on a redirect edge belongs to the abandoned path.
  assign push        = xfer && (state != DROP) && !redirect && !bypass;
  assign pop         = !hold && !redirect && !fifo_empty;
  assign count_after = fifo_count + CNT_W'(push) - CNT_W'(pop);
  assign room        = (count_after < CNT_W'(FIFO_DEPTH));

  if_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (redirect),
    .push  (push),
    .pop   (pop),
    .wdata ({imem_addr_o, imem_data_i}),
    .rdata (fifo_head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      imem_req_o  <= 1'b0;
      imem_addr_o <= RESET_PC;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      imem_req_o  <= req_nxt;
      imem_addr_o <= addr_nxt;
    end
  end

  // A new request may be issued on the same edge the previous one is acked.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    req_nxt   = imem_req_o;
    addr_nxt  = imem_addr_o;
    case (state)
      FETCH: begin
        if (redirect) begin
          pc_nxt = branch_addr_i;
          if (imem_req_o && !imem_ack_i) state_nxt = DROP;
          else                           req_nxt   = 1'b0;
        end else if (!imem_req_o || imem_ack_i) begin
          if (room) begin
            req_nxt  = 1'b1;
            addr_nxt = pc;
            pc_nxt   = pc + ADDR_W'(1);
          end else begin
            req_nxt   = 1'b0;
            state_nxt = FULL;
          end
        end
      end
      FULL: begin
        req_nxt = 1'b0;
        if (redirect) begin
          pc_nxt    = branch_addr_i;
          state_nxt = FETCH;
        end else if (room) begin
          state_nxt = FETCH;
        end
      end
      DROP: begin
        if (redirect) pc_nxt = branch_addr_i;
        if (xfer) begin
          req_nxt   = 1'b0;
          state_nxt = FETCH;
        end
      end
      default: begin
        req_nxt   = 1'b0;
        state_nxt = FETCH;
      end
    endcase
  end

  // Output register: a redirect squashes it to a bubble; pc_o keeps its last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      pc_o    <= '0;
      inst_o  <= NOP_INST;
      valid_o <= 1'b0;
    end else if (redirect) begin
      inst_o  <= NOP_INST;
      valid_o <= 1'b0;
    end else if (!hold) begin
      if (bypass) begin
        pc_o    <= imem_addr_o;
        inst_o  <= imem_data_i;
        valid_o <= 1'b1;
      end else if (!fifo_empty) begin
        {pc_o, inst_o} <= fifo_head;
        valid_o        <= 1'b1;
      end else begin
        inst_o  <= NOP_INST;
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage of the 16-bit MIPS16-style pipeline; sits directly upstream of the decode stage.
- Owns the PC and drives a single-outstanding req/ack handshake to instruction memory.
- Buffers fetched words in a small FIFO so decode stalls do not block memory.
- Presents a registered {pc_o, inst_o} pair to decode, and applies the branch redirect that decode produces.

Parameters:
ADDR_W, 16, instruction address width (word addressed, PC step = 1)
DATA_W, 16, instruction width
RESET_PC, 16'h0000, first fetch address after reset
NOP_INST, 16'h0800, bubble encoding driven on inst_o when no valid instruction
FIFO_DEPTH, 2, fetch buffer entries (power of two, >= 2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high (RstEnable = 1)
stall_i  in  1  decode/ctrl stall; hold output register, no pop
branch_flag_i  in  1  redirect request from decode
branch_addr_i  in  ADDR_W  redirect target
imem_req_o  out  1  fetch request, held until acked
imem_addr_o  out  ADDR_W  fetch address, stable while imem_req_o=1
imem_ack_i  in  1  memory accepts and returns data this cycle
imem_data_i  in  DATA_W  instruction word, valid when imem_ack_i=1
pc_o  out  ADDR_W  PC of instruction presented to decode
inst_o  out  DATA_W  instruction presented to decode
valid_o  out  1  pc_o/inst_o hold a real instruction

Behaviour:
- Reset (async): pc=RESET_PC, FIFO empty, state=FETCH, imem_req_o=0, imem_addr_o=RESET_PC, pc_o=0, inst_o=NOP_INST, valid_o=0.
- Request is registered: in FETCH with no request outstanding, set imem_req_o=1 and imem_addr_o=pc on the next edge, and advance pc by 1 (modulo 2^ADDR_W, 16'hFFFF wraps to 0).
- Handshake: transfer completes on the edge where imem_req_o=1 and imem_ack_i=1. Ack is allowed in the first request cycle. imem_addr_o and imem_req_o never change while a request is unacked, except on reset.
- Issue rule: a new request is issued only if FIFO count plus outstanding requests is less than FIFO_DEPTH. Back-to-back requests on consecutive edges are allowed when there is room.
- States:
  - FETCH: requesting or ready to request.
  - FULL: no room, imem_req_o=0; return to FETCH when a pop frees an entry.
  - DROP: redirect arrived while a request was unacked; keep the old request until ack, discard its data, then go to FETCH.
- Push: acked data with its address is written to the FIFO tail, except in DROP.
- Output register, updated on the edge when stall_i=0:
  - FIFO non-empty: load head, pop, valid_o=1.
  - FIFO empty: inst_o=NOP_INST, valid_o=0, pc_o unchanged.
- stall_i=1: output register, FIFO head and pc_o/inst_o are held. Fetching continues until the FIFO is full.
- Push and pop may occur on the same edge; count is unchanged and ordering is preserved.
- Redirect: acts on the edge where branch_flag_i=1 and stall_i=0; ignored while stall_i=1.
  - There is no delay slot.
  - FIFO is cleared, output register loads the bubble (NOP_INST, valid_o=0), pc=branch_addr_i.
  - If a request is unacked, go to DROP.
  - If an ack lands on the redirect edge, drop that data and go to FETCH.
  - Redirect while in DROP updates pc and stays in DROP.
- Latency (without bypass): ack at edge N; instruction is visible on inst_o after edge N+1 when stall_i=0.
- Reset mid-request: imem_req_o is deasserted immediately; instruction memory tolerates the aborted request.

Optional Feature:
- Macro IF_FETCH_BYPASS_EN.
- Defined: when the FIFO is empty, stall_i=0 and an ack arrives outside DROP, imem_data_i loads the output register directly on that edge, skipping the FIFO. Latency becomes 0 edges after ack.
- Undefined: all data passes through the FIFO; latency is 1 edge.

Decomposition:
- Shared package (defines): RstEnable, NOP_INST encoding, InstAddrBus/InstBus widths, ZeroInstAddr, StallYes/StallNo, BranchFlagUp/BranchFlagDown, and the fetch state encodings FETCH/FULL/DROP.
- Sub-module if_fifo: parameterized sync FIFO with push/pop/clear and count.

Test Plan:
- Reset, memory acks every request in its first cycle: addresses 0,1,2,3 issued. Outputs pc_o=0,1,2,3 on successive edges with valid_o=1. Before the first delivery, inst_o=16'h0800 and valid_o=0.
- stall_i held 5 cycles: exactly 2 extra fetches complete, then imem_req_o=0 (FULL). On release, the held and buffered instructions emerge in order with no loss or duplication.
- Memory acks 3 cycles late: imem_addr_o is stable for all 3 cycles and imem_req_o does not drop.
- Redirect to 16'h0040 while a fetch to 16'h0005 is unacked: the 16'h0005 data is discarded when acked, the next request is 16'h0040, and output is a bubble until pc_o=16'h0040.
- Redirect asserted with stall_i=1: no effect. Redirect is taken on the first unstalled edge.
- pc=16'hFFFF: the next fetch address is 16'h0000. Async rst pulse mid-request clears imem_req_o immediately.
